// File: rtl/trivium_out_fifo.sv
// First-word-fall-through output buffer behind the Trivium core: a memory ring plus
// an output register, with burst-room status (fifo_cnd) and sticky overflow.
module trivium_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned BURST = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     out_ready,
  input  logic                     clr_err,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               fifo_cnd
);

  localparam int unsigned LW        = $clog2(DEPTH) + 1;
  localparam int unsigned MEM_DEPTH = DEPTH - 1;
  localparam int unsigned AW        = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t           sc;
  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             push;
  logic             drop;
  logic             load;
  logic             mem_empty;
  logic             mem_wr;
  logic             ovf_next;
  logic [LW-1:0]    mem_cnt;
  logic [LW-1:0]    level_next;

  // Ring of DEPTH-1 words: pointers wrap with no unused slot.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MEM_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    pop        = out_valid && out_ready;
    push       = wr_en && ((level < LW'(DEPTH)) || pop);
    drop       = wr_en && !push;
    mem_cnt    = level - LW'(out_valid);
    mem_empty  = (mem_cnt == '0);
    load       = !out_valid || pop;
    // Bypass straight into the output register when the ring has nothing older.
    mem_wr     = push && !(load && mem_empty);
    level_next = level + LW'(push) - LW'(pop);
    ovf_next   = drop || ((sc == S_ERR) && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      level     <= '0;
    end else begin
      level <= level_next;
      if (mem_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (load) begin
        if (!mem_empty) begin
          out_data  <= mem[rd_ptr];
          rd_ptr    <= ptr_inc(rd_ptr);
          out_valid <= 1'b1;
        end else if (push) begin
          out_data  <= wr_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Status FSM: ERR dominates; otherwise state and fifo_cnd follow level_next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc       <= S_EMPTY;
      fifo_cnd <= 2'b00;
    end else if (ovf_next) begin
      sc       <= S_ERR;
      fifo_cnd <= 2'b11;
    end else if (level_next == LW'(DEPTH)) begin
      sc       <= S_FULL;
      fifo_cnd <= 2'b10;
    end else begin
      sc       <= (level_next == '0) ? S_EMPTY : S_ACTIVE;
      fifo_cnd <= ((LW'(DEPTH) - level_next) >= LW'(BURST)) ? 2'b00 : 2'b01;
    end
  end

endmodule

// File: tb/tb_trivium_out_fifo.sv
// Scoreboard bench for trivium_out_fifo: directed scenarios plus random traffic
// checked against a queue-based occupancy/status model.
module tb_trivium_out_fifo;

  localparam int DEPTH = 512;
  localparam int BURST = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        out_ready;
  logic        clr_err;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [9:0]  level;
  logic [1:0]  fifo_cnd;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  int          m_level = 0;
  bit          m_ovf = 1'b0;
  int          m_cnd = 0;

  trivium_out_fifo #(.WIDTH(8), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .out_ready(out_ready), .clr_err(clr_err), .out_valid(out_valid),
    .out_data(out_data), .level(level), .fifo_cnd(fifo_cnd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference occupancy/status model, advanced on each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 0;
      m_ovf   = 1'b0;
      m_cnd   = 0;
    end else begin
      int pop_m, push_m;
      pop_m  = (m_level > 0 && out_ready) ? 1 : 0;
      push_m = (wr_en && (m_level < DEPTH || pop_m == 1)) ? 1 : 0;
      if (wr_en && push_m == 0) m_ovf = 1'b1;
      else if (clr_err)         m_ovf = 1'b0;
      m_level = m_level + push_m - pop_m;
      if (m_ovf)                        m_cnd = 3;
      else if (m_level == DEPTH)        m_cnd = 2;
      else if (DEPTH - m_level >= BURST) m_cnd = 0;
      else                              m_cnd = 1;
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("level", int'(level), m_level);
      check("out_valid", int'(out_valid), (m_level > 0) ? 1 : 0);
      check("fifo_cnd", int'(fifo_cnd), m_cnd);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_with_empty_queue", int'(out_valid), 0);
        else                   check("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  // One cycle of stimulus; the accepted byte is queued as an expected output.
  task automatic step(input bit we, input logic [7:0] wd, input bit rdy, input bit clr);
    bit pop_s;
    wr_en     = we;
    wr_data   = wd;
    out_ready = rdy;
    clr_err   = clr;
    pop_s     = (m_level > 0) && rdy;
    if (we && (m_level < DEPTH || pop_s)) exp_q.push_back(wd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    rst       = 1'b1;
    exp_q.delete();
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_fifo_cnd", int'(fifo_cnd), 0);
    check("rst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    #2;
    do_reset();

    // Single byte latency through an empty FIFO
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("t2_valid", int'(out_valid), 1);
    check("t2_data", int'(out_data), 'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_valid_after", int'(out_valid), 0);
    check("t2_level", int'(level), 0);

    // Fill with out_ready low and watch the burst-room status
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("t3_level256", int'(level), 256);
    check("t3_cnd256", int'(fifo_cnd), 0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("t3_cnd257", int'(fifo_cnd), 1);
    for (int i = 1; i < 256; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("t3_level512", int'(level), 512);
    check("t3_cnd_full", int'(fifo_cnd), 2);

    // Overflow drop and clear
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("t4_cnd_err", int'(fifo_cnd), 3);
    check("t4_level", int'(level), 512);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_cnd_clr", int'(fifo_cnd), 2);

    // Drain; scoreboard confirms order and absence of the dropped byte
    for (int i = 0; i < 512; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_drained_level", int'(level), 0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Full-rate streaming at full occupancy across pointer wrap
    for (int i = 0; i < 512; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b1, 8'(i + 7), 1'b1, 1'b0);
    check("t5_level", int'(level), 512);
    check("t5_cnd", int'(fifo_cnd), 2);

    // Random traffic with a reset dropped in mid-stream
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        do_reset();
        check("t1_queue_cleared", int'(level), exp_q.size());
      end
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0));
      check("t6_level_vs_queue", int'(level), exp_q.size() - ((out_valid && out_ready) ? 0 : 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
